// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, default reset vector and fetch-stage types.
package cpu_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0001_0000;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W queue with clear, count, registered head and same-cycle push/pop.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic pop_ok;
   assign valid = count != '0;
   assign pop_ok = pop && valid;
   assign dout = mem[rd_ptr];
   // storage, pointers and occupancy; a full-queue push+pop reuses the slot just popped
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= din;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop_ok);
      end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetch into a DEPTH-entry queue with redirect flush.
// Define PFQ_PERF_EN to add the saturating flush_cnt / stall_cnt counters.
module fetch_prefetch_queue
   import cpu_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [ILEN-1:0] mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
`ifdef PFQ_PERF_EN
   ,
   output logic [15:0]     flush_cnt,
   output logic [31:0]     stall_cnt
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   fetch_state_t state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
   logic [CW-1:0] count, count_after;
   logic push, pop, slot_free;
   fetch_entry_t entry, head;
   assign mem_addr = fetch_pc_q;
   assign entry = '{pc: req_pc_q, instr: mem_rdata};
   assign out_pc = head.pc;
   assign out_instr = head.instr;
   // state, fetch pointer, address of the granted request and registered mem_req
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q <= RESET_PC;
         mem_req <= 1'b0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (state_q == REQ && mem_gnt) req_pc_q <= fetch_pc_q;
         mem_req <= state_d == REQ;
      end
   // next state; a redirect with a granted-but-unanswered request must drop the stale response
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = (redirect || slot_free) ? REQ : IDLE;
         REQ:  state_d = mem_gnt ? (redirect ? DROP : WAIT) : REQ;
         WAIT: state_d = mem_rvalid ? ((redirect || slot_free) ? REQ : IDLE) : (redirect ? DROP : WAIT);
         DROP: state_d = mem_rvalid ? REQ : DROP;
         default: state_d = IDLE;
      endcase
   end
   // queue controls, slot reservation and next fetch address; redirect masks push and pop
   always_comb begin
      push = state_q == WAIT && mem_rvalid && !redirect;
      pop = out_valid && out_ready && !redirect;
      count_after = count + CW'(push) - CW'(pop);
      slot_free = count_after < CW'(DEPTH);
      fetch_pc_d = redirect ? {redirect_pc[XLEN-1:2], 2'b00} :
                   (state_q == REQ && mem_gnt) ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
   end
   sync_fifo #(.DEPTH(DEPTH), .W(XLEN + ILEN)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (redirect),
      .push  (push),
      .din   (entry),
      .pop   (pop),
      .dout  (head),
      .valid (out_valid),
      .count (count)
   );
`ifdef PFQ_PERF_EN
   // saturating redirect and consumer-starvation counters
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         flush_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + 16'd1;
         if (out_ready && !out_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard bench for fetch_prefetch_queue; build with PFQ_PERF_EN to cover the counters.
module tb_fetch_prefetch_queue;
   logic clk, rst, mem_req, mem_gnt, mem_rvalid, out_valid, out_ready, redirect;
   logic [31:0] mem_addr, mem_rdata, out_instr, out_pc, redirect_pc;
`ifdef PFQ_PERF_EN
   logic [15:0] flush_cnt;
   logic [31:0] stall_cnt;
`endif
   int vecs = 0, errs = 0, grants = 0, budget = 0, lat = 0;
   logic [31:0] mask = 32'h0;
   logic [63:0] exp_q[$];

   fetch_prefetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef PFQ_PERF_EN
      ,
      .flush_cnt   (flush_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_fetch(input logic [31:0] pc);
      exp_q.push_back({pc, pc ^ mask});
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
      chk(name, exp_q.size(), 0);
   endtask

   task automatic wait_grant(input string name);
      int g0 = grants;
      for (int i = 0; i < 50 && grants == g0; i++) tick(1);
      chk(name, 64'(grants != g0), 1);
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 50 && !mem_req; i++) tick(1);
      chk(name, mem_req, 1);
   endtask

   // memory model: grants while budget lasts, answers the granted address after lat extra cycles
   initial begin
      logic pend;
      logic [31:0] paddr;
      int pdelay;
      pend = 1'b0;
      paddr = 32'h0;
      pdelay = 0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req && mem_gnt) begin
            pend = 1'b1;
            paddr = mem_addr;
            pdelay = lat;
            grants++;
            budget--;
         end
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pend && pdelay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = paddr ^ mask;
            pend = 1'b0;
         end else if (pend) pdelay--;
         mem_gnt = budget > 0;
      end
   end

   // monitor: every accepted head entry must be the oldest expected fetch
   initial forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected head: got pc %h instr %h, expected no entry", out_pc, out_instr);
         end else chk("head entry", {out_pc, out_instr}, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      tick(2);
      chk("reset mem_req", mem_req, 0);
      chk("reset mem_addr", mem_addr, 32'h0001_0000);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_pc", out_pc, 0);
      chk("reset out_instr", out_instr, 0);
      // 1: zero-wait memory, addr-as-data, three fetches
      budget = 3;
      tick(2);
      expect_fetch(32'h0001_0000);
      expect_fetch(32'h0001_0004);
      expect_fetch(32'h0001_0008);
      out_ready = 1'b1;
      rst = 1'b0;
      tick(1);
      chk("first req", mem_req, 1);
      chk("first addr", mem_addr, 32'h0001_0000);
      drain("t1 drain");
      chk("t1 held req", mem_req, 1);
      chk("t1 held addr", mem_addr, 32'h0001_000C);
      // 2: backpressure fills exactly DEPTH slots
      mask = 32'hFFFF_0000;
      out_ready = 1'b0;
      grants = 0;
      budget = 5;
      expect_fetch(32'h0001_000C);
      expect_fetch(32'h0001_0010);
      expect_fetch(32'h0001_0014);
      expect_fetch(32'h0001_0018);
      expect_fetch(32'h0001_001C);
      tick(20);
      chk("full grants", grants, 4);
      chk("full no req", mem_req, 0);
      chk("full valid", out_valid, 1);
      chk("full head pc", out_pc, 32'h0001_000C);
      chk("full head instr", out_instr, 32'hFFFE_000C);
      out_ready = 1'b1;
      tick(1);
      chk("resume req", mem_req, 1);
      chk("resume addr", mem_addr, 32'h0001_001C);
      drain("t2 drain");
      // 3: redirect while waiting for data; stale response dropped
      lat = 3;
      budget = 1;
      wait_grant("t3 grant");
      redirect = 1'b1;
      redirect_pc = 32'h0001_0103;
      tick(1);
      redirect = 1'b0;
      lat = 0;
      budget = 2;
      expect_fetch(32'h0001_0100);
      expect_fetch(32'h0001_0104);
      chk("t3 flushed", out_valid, 0);
      chk("t3 dropping", mem_req, 0);
      wait_req("t3 restart");
      chk("t3 addr", mem_addr, 32'h0001_0100);
      drain("t3 drain");
      // 4: redirect with same-cycle pop on a full queue
      out_ready = 1'b0;
      budget = 4;
      tick(20);
      chk("t4 full", out_valid, 1);
      chk("t4 head", out_pc, 32'h0001_0108);
      chk("t4 idle", mem_req, 0);
      out_ready = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0002_0000;
      tick(1);
      redirect = 1'b0;
      chk("t4 cleared", out_valid, 0);
      chk("t4 req", mem_req, 1);
      chk("t4 addr", mem_addr, 32'h0002_0000);
      budget = 3;
      expect_fetch(32'h0002_0000);
      expect_fetch(32'h0002_0004);
      expect_fetch(32'h0002_0008);
      drain("t4 drain");
      // 5: fetch address wraps at 2^32, low redirect bits forced to zero
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      tick(1);
      redirect = 1'b0;
      chk("t5 addr", mem_addr, 32'hFFFF_FFFC);
      chk("t5 req", mem_req, 1);
      budget = 2;
      expect_fetch(32'hFFFF_FFFC);
      expect_fetch(32'h0000_0000);
      wait_grant("t5 grant");
      chk("t5 wrap", mem_addr, 32'h0000_0000);
      drain("t5 drain");
      // 6: asynchronous reset mid-WAIT; late response ignored
      budget = 1;
      lat = 3;
      wait_grant("t6 grant");
      #2;
      rst = 1'b1;
      #1;
      chk("t6 rst mem_req", mem_req, 0);
      chk("t6 rst mem_addr", mem_addr, 32'h0001_0000);
      chk("t6 rst out_valid", out_valid, 0);
      chk("t6 rst out_pc", out_pc, 0);
      chk("t6 rst out_instr", out_instr, 0);
`ifdef PFQ_PERF_EN
      chk("t6 rst flush_cnt", flush_cnt, 0);
      chk("t6 rst stall_cnt", stall_cnt, 0);
`endif
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("t6 req", mem_req, 1);
      chk("t6 addr", mem_addr, 32'h0001_0000);
      tick(3);
      chk("t6 late ignored", out_valid, 0);
      chk("t6 still req", mem_req, 1);
      chk("t6 still addr", mem_addr, 32'h0001_0000);
      lat = 0;
      budget = 2;
      expect_fetch(32'h0001_0000);
      expect_fetch(32'h0001_0004);
      drain("t6 drain");
`ifdef PFQ_PERF_EN
      // 7: redirect counter
      for (int i = 0; i < 3; i++) begin
         redirect = 1'b1;
         redirect_pc = 32'h0003_0000;
         tick(1);
         redirect = 1'b0;
         tick(1);
      end
      chk("flush_cnt", flush_cnt, 3);
`endif
      tick(5);
      chk("leftover", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
